// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and widths for the buffered data memory
package dmem_pkg;

  localparam int N_DEF         = 64;
  localparam int MEM_WORDS_DEF = 256;
  localparam int WB_DEPTH_DEF  = 4;

  localparam int IDX_W = $clog2(MEM_WORDS_DEF);
  localparam int PTR_W = $clog2(WB_DEPTH_DEF);
  localparam int CNT_W = $clog2(WB_DEPTH_DEF + 1);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [63:0]      data;
  } wbuf_entry_t;

endpackage

// File: rtl/dmem_wbuf_fifo.sv
// rtl/dmem_wbuf_fifo.sv - circular posted-store buffer with youngest-match lookup
module wbuf_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enq,
  input  logic [IDX_W-1:0]             enq_idx,
  input  logic [63:0]                  enq_data,
  input  logic                         deq,
  output logic [IDX_W-1:0]             head_idx,
  output logic [63:0]                  head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  input  logic [IDX_W-1:0]             lookup_idx,
  output logic                         hit,
  output logic [63:0]                  hit_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wbuf_entry_t   ent [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] p;

  // Pointer/count bookkeeping; caller guarantees enq only when not full, deq only when not empty
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
    end else begin
      if (enq) begin
        ent[tail] <= '{valid: 1'b1, idx: enq_idx, data: enq_data};
        tail      <= tail + PW'(1);
      end
      if (deq) begin
        ent[head].valid <= 1'b0;
        head            <= head + PW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Walk entries oldest to youngest so the last hit seen is the youngest
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    p        = head;
    for (int k = 0; k < DEPTH; k++) begin
      p = head + PW'(k);
      if (ent[p].valid && (ent[p].idx == lookup_idx)) begin
        hit      = 1'b1;
        hit_data = ent[p].data;
      end
    end
  end

  assign head_idx  = ent[head].idx;
  assign head_data = ent[head].data;

endmodule

// File: rtl/dmem_wbuf.sv
// rtl/dmem_wbuf.sv - single-port data memory with posted write buffer
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int WB_DEPTH  = WB_DEPTH_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N-1:0]                    DM_addr,
  input  logic [N-1:0]                    DM_writeData,
  input  logic                            DM_writeEnable,
  input  logic                            DM_readEnable,
  output logic [N-1:0]                    DM_readData,
  output logic                            dm_stall,
  output logic [$clog2(WB_DEPTH+1)-1:0]   wbuf_count,
  output logic                            wbuf_empty
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(WB_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WB_DEPTH);

  logic [N-1:0]  mem [MEM_WORDS];
  logic [IW-1:0] idx;
  logic          accept;
  logic          drain;
  logic [IW-1:0] head_idx;
  logic [N-1:0]  head_data;
  logic          hit;
  logic [N-1:0]  hit_data;
  logic          unused_addr_bits;

  // Byte offset and bits above the word index are don't-care: accesses wrap
  assign idx              = DM_addr[IW+2:3];
  assign unused_addr_bits = ^{DM_addr[N-1:IW+3], DM_addr[2:0]};

  // Reads own the single array port, so a read cycle blocks the drain
  assign accept     = DM_writeEnable && (wbuf_count < FULL);
  assign drain      = (wbuf_count != '0) && !DM_readEnable;
  assign dm_stall   = DM_writeEnable && (wbuf_count == FULL);
  assign wbuf_empty = (wbuf_count == '0);

  wbuf_fifo #(.DEPTH(WB_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .enq        (accept),
    .enq_idx    (idx),
    .enq_data   (DM_writeData),
    .deq        (drain),
    .head_idx   (head_idx),
    .head_data  (head_data),
    .count      (wbuf_count),
    .lookup_idx (idx),
    .hit        (hit),
    .hit_data   (hit_data)
  );

  // Retire the oldest buffered store; reset discards it instead
  always_ff @(posedge clk) begin
    if (reset && drain) mem[head_idx] <= head_data;
  end

  // Buffered data shadows the array; a same-cycle store is not yet visible
  always_comb begin
    DM_readData = '0;
    if (DM_readEnable) DM_readData = hit ? hit_data : mem[idx];
  end

endmodule

// File: tb/tb_dmem_wbuf.sv
// tb/tb_dmem_wbuf.sv - randomized self-checking bench for dmem_wbuf
module tb_dmem_wbuf;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] DM_addr = '0;
  logic [63:0] DM_writeData = '0;
  logic        DM_writeEnable = 1'b0;
  logic        DM_readEnable = 1'b0;
  logic [63:0] DM_readData;
  logic        dm_stall;
  logic [2:0]  wbuf_count;
  logic        wbuf_empty;

  dmem_wbuf dut (
    .clk            (clk),
    .reset          (reset),
    .DM_addr        (DM_addr),
    .DM_writeData   (DM_writeData),
    .DM_writeEnable (DM_writeEnable),
    .DM_readEnable  (DM_readEnable),
    .DM_readData    (DM_readData),
    .dm_stall       (dm_stall),
    .wbuf_count     (wbuf_count),
    .wbuf_empty     (wbuf_empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: an ordered list of pending stores plus a flat word array
  logic [63:0] mem_m [256];
  int          q_idx [$];
  logic [63:0] q_dat [$];

  logic [63:0] last_rd;
  logic        last_stall;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [63:0] model_read(input logic re, input logic [63:0] addr);
    int w;
    logic [63:0] v;
    w = int'(addr[10:3]);
    if (!re) return 64'h0;
    v = mem_m[w];
    foreach (q_idx[i]) if (q_idx[i] == w) v = q_dat[i];
    return v;
  endfunction

  task automatic step(input logic rst, input logic we, input logic re,
                      input logic [63:0] addr, input logic [63:0] data);
    bit acc, drn;
    @(negedge clk);
    reset = rst; DM_writeEnable = we; DM_readEnable = re;
    DM_addr = addr; DM_writeData = data;
    #1;
    chk("rdata", DM_readData, model_read(re, addr));
    chk("stall", {63'd0, dm_stall}, {63'd0, we && (q_idx.size() == 4)});
    chk("count", {61'd0, wbuf_count}, 64'(q_idx.size()));
    chk("empty", {63'd0, wbuf_empty}, {63'd0, q_idx.size() == 0});
    last_rd = DM_readData;
    last_stall = dm_stall;
    @(posedge clk);
    if (!rst) begin
      q_idx.delete();
      q_dat.delete();
    end else begin
      acc = we && (q_idx.size() < 4);
      drn = (q_idx.size() > 0) && !re;
      if (drn) begin
        mem_m[q_idx[0]] = q_dat[0];
        void'(q_idx.pop_front());
        void'(q_dat.pop_front());
      end
      if (acc) begin
        q_idx.push_back(int'(addr[10:3]));
        q_dat.push_back(data);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
  endtask

  function automatic logic [63:0] init_val(input int w);
    return 64'hA5A5_0000_0000_0000 | 64'(w);
  endfunction

  initial begin
    logic [63:0] a;
    logic [63:0] d;
    bit we, re;

    // Power-on reset
    reset = 1'b0;
    repeat (2) @(posedge clk);
    step(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
    chk("reset_count", {61'd0, wbuf_count}, 64'd0);
    chk("reset_empty", {63'd0, wbuf_empty}, 64'd1);

    // Give words 0..31 known contents
    for (int w = 0; w < 32; w++) step(1'b1, 1'b1, 1'b0, 64'(w) << 3, init_val(w));
    idle(2);

    // Store then load
    step(1'b1, 1'b1, 1'b0, 64'h40, 64'h1122334455667788);
    chk("st_count1", {61'd0, wbuf_count}, 64'd0);
    idle(1);
    step(1'b1, 1'b0, 1'b1, 64'h40, 64'h0);
    chk("st_then_ld", last_rd, 64'h1122334455667788);
    chk("st_mem8", mem_m[8], 64'h1122334455667788);

    // Forwarding under a read stream
    step(1'b1, 1'b1, 1'b1, 64'h10, 64'd5);
    step(1'b1, 1'b1, 1'b1, 64'h10, 64'd9);
    step(1'b1, 1'b0, 1'b1, 64'h10, 64'h0);
    chk("fwd_rd1", last_rd, 64'd9);
    step(1'b1, 1'b0, 1'b1, 64'h10, 64'h0);
    chk("fwd_rd2", last_rd, 64'd9);
    chk("fwd_cnt", {61'd0, wbuf_count}, 64'd2);
    idle(3);
    step(1'b1, 1'b0, 1'b1, 64'h10, 64'h0);
    chk("fwd_drained", last_rd, 64'd9);

    // Full buffer with reads blocking drain
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b1, 64'h50 + 64'(k * 8), 64'h100 + 64'(k));
    step(1'b1, 1'b1, 1'b1, 64'h70, 64'h777);
    chk("full_stall1", {63'd0, last_stall}, 64'd1);
    step(1'b1, 1'b1, 1'b1, 64'h70, 64'h777);
    chk("full_stall2", {63'd0, last_stall}, 64'd1);
    step(1'b1, 1'b1, 1'b0, 64'h70, 64'h777);
    chk("full_stall_drain", {63'd0, last_stall}, 64'd1);
    step(1'b1, 1'b1, 1'b0, 64'h70, 64'h777);
    chk("full_accept", {63'd0, last_stall}, 64'd0);
    idle(6);

    // Same-cycle load and store
    step(1'b1, 1'b1, 1'b0, 64'h20, 64'd7);
    idle(2);
    step(1'b1, 1'b1, 1'b1, 64'h20, 64'd3);
    chk("rw_old", last_rd, 64'd7);
    step(1'b1, 1'b0, 1'b1, 64'h20, 64'h0);
    chk("rw_new", last_rd, 64'd3);
    idle(3);

    // Reset mid-operation
    step(1'b1, 1'b1, 1'b1, 64'h80, 64'hDEAD0);
    step(1'b1, 1'b1, 1'b1, 64'h88, 64'hDEAD1);
    step(1'b1, 1'b1, 1'b1, 64'h90, 64'hDEAD2);
    step(1'b0, 1'b1, 1'b0, 64'h98, 64'hDEAD3);
    step(1'b1, 1'b0, 1'b1, 64'h80, 64'h0);
    chk("rst_count", {61'd0, wbuf_count}, 64'd0);
    chk("rst_empty", {63'd0, wbuf_empty}, 64'd1);
    chk("rst_rd80", last_rd, init_val(16));
    step(1'b1, 1'b0, 1'b1, 64'h98, 64'h0);
    chk("rst_rd98", last_rd, init_val(19));

    // Address wrap and ignored byte offset
    step(1'b1, 1'b1, 1'b0, 64'd256 * 8 + 64'h8, 64'hAB);
    idle(2);
    step(1'b1, 1'b0, 1'b1, 64'h8, 64'h0);
    chk("wrap_rd", last_rd, 64'hAB);
    step(1'b1, 1'b0, 1'b1, 64'hD, 64'h0);
    chk("wrap_off5", last_rd, 64'hAB);

    // Randomized traffic over words 0..31 with random high and offset bits
    for (int n = 0; n < 600; n++) begin
      a = {$urandom(), $urandom()};
      a[10:3] = 8'($urandom_range(0, 31));
      d = {$urandom(), $urandom()};
      we = ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < 50);
      step(($urandom_range(0, 99) != 0), we, re, a, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_wbuf.md
Name: dmem_wbuf

Overview:
- Data-memory responder on the far side of the pipeline's DM interface.
- Services DM_readEnable/DM_writeEnable requests from the MEM stage.
- Word array has one port. Stores are posted into a small write buffer that drains to the array on cycles with no read.
- Reads return data combinationally in the same cycle, with youngest-match forwarding from the buffer.
- Raises dm_stall when a store arrives while the buffer is full, for OR-ing into the pipeline stall.

Parameters:
N, 64, data and address width
MEM_WORDS, 256, number of 64-bit words in the array (power of two)
WB_DEPTH, 4, write-buffer entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset (0 at a clk edge resets)
DM_addr  in  N  byte address; word index = DM_addr[$clog2(MEM_WORDS)+2:3]
DM_writeData  in  N  store data
DM_writeEnable  in  1  store request
DM_readEnable  in  1  load request
DM_readData  out  N  load data, combinational
dm_stall  out  1  store not accepted this cycle; requester must hold the request
wbuf_count  out  $clog2(WB_DEPTH+1)  valid buffer entries (registered)
wbuf_empty  out  1  wbuf_count==0

Behaviour:
- Address mapping:
  - DM_addr[2:0] is ignored (word-aligned access only).
  - Upper bits above the index are ignored, so addresses wrap modulo MEM_WORDS.
- Read path (combinational):
  - When DM_readEnable=0, DM_readData=0.
  - Otherwise, the youngest valid buffer entry with a matching index supplies the data.
  - With no match, the data comes from mem[index].
  - A store presented in the same cycle is not visible to the read; the read returns the pre-store value.
- Store accept:
  - The accept condition is DM_writeEnable & (wbuf_count<WB_DEPTH), using the registered count.
  - On accept, {index, DM_writeData} is written at the tail on the next edge and the tail advances.
- dm_stall = DM_writeEnable & (wbuf_count==WB_DEPTH).
  - It is purely combinational and does not depend on DM_readEnable.
  - When full with no read, the drain still happens this cycle, but the store is only accepted the following cycle.
- Drain:
  - Occurs when wbuf_count>0 & DM_readEnable=0.
  - The head entry is written to mem on the edge, the head advances, and the entry is invalidated.
  - A read cycle blocks the drain (single port; the read has priority).
- Count update:
  - +1 on accept only, -1 on drain only.
  - Unchanged when both or neither occur.
  - Never exceeds WB_DEPTH and never underflows.
- Head and tail pointers wrap modulo WB_DEPTH. Full and empty are distinguished by count, not by pointer equality.
- Same-index entries: multiple buffered stores to one index are all kept. Drain order is FIFO, so the array ends with the youngest value.
- Simultaneous read and write (not issued by the LEGv8 pipeline, but defined): both are serviced per the rules above; the drain is blocked.
- Reset (reset=0 at an edge):
  - head, tail and count go to 0 and all valid bits clear; pending stores are discarded.
  - mem contents are not reset.
  - wbuf_count=0 and wbuf_empty=1 from the edge onward.
  - dm_stall=0 after the reset edge, since count is 0.
- Reset asserted mid-operation with requests active: the reset wins; any store presented that cycle is dropped.
- Latency:
  - Reads take 0 cycles.
  - A store becomes visible to reads one edge after accept, via forwarding.
  - A store reaches the array at the earliest 1 edge after accept.

Decomposition:
- Package dmem_pkg:
  - wbuf_entry_t struct {logic valid; logic [IDX_W-1:0] idx; logic [63:0] data}
  - localparams IDX_W and PTR_W derived from the defaults
- Sub-module wbuf_fifo: circular buffer with head/tail/count, enqueue/dequeue ports, and a parallel index match returning the youngest hit.
- dmem_wbuf holds the mem array, the read mux, and the stall/drain arbitration.

Test Plan:
- Store then load, no intervening read: write 0x1122334455667788 @0x40, idle 1 cycle, read @0x40 -> 0x1122334455667788. wbuf_count goes 1 then 0; mem[8] is updated.
- Forwarding under a back-to-back read stream:
  - Stimulus: store @0x10=5, store @0x10=9, then continuous reads @0x10.
  - Response: both reads return 9; count holds at 2 while reads continue; reads still return 9 after drain completes.
- Full buffer:
  - Stimulus: 4 stores to distinct addresses while reading every cycle (no drain), then a 5th store with reads still active.
  - Response: dm_stall=1 for as long as reads continue and the 5th store is held.
  - Stop reads: drain occurs that cycle, the 5th store is accepted on the next cycle, and dm_stall drops.
- Same-cycle load and store to the same address @0x20 (old value 7, new 3): DM_readData=7 that cycle; 3 on the next read.
- Reset mid-operation: 3 stores buffered, reset=0 for 1 edge -> wbuf_count=0, wbuf_empty=1. Reads of those addresses return the prior array values.
- Address wrap: store @(MEM_WORDS*8+0x8)=0xAB, drain, read @0x8 -> 0xAB; DM_addr[2:0]=5 is ignored.
